// File: rtl/hp0_stream_wr_master.sv
// AXI3 write initiator for PS S_AXI_HP0: buffers a 32-bit stream and writes it to DDR in 16-beat INCR bursts.
// Optional build macro HP0_WR_RING_EN: circular capture over the programmed region until cfg_stop.
module hp0_stream_wr_master #(
    parameter logic [5:0] AXI_ID     = 6'd0,
    parameter int         FIFO_DEPTH = 32,
    parameter int         BURST_LEN  = 16
) (
    input  logic        SYS_CLK,
    input  logic        SYS_RST,
    input  logic [31:0] cfg_base,
    input  logic [23:0] cfg_words,
    input  logic        cfg_start,
    input  logic        cfg_stop,
    output logic        sts_busy,
    output logic        sts_done,
    output logic        sts_err,
    output logic [31:0] sts_addr,
    input  logic [31:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [31:0] M_AXI_awaddr,
    output logic [3:0]  M_AXI_awlen,
    output logic [5:0]  M_AXI_awid,
    output logic [2:0]  M_AXI_awsize,
    output logic [1:0]  M_AXI_awburst,
    output logic [3:0]  M_AXI_awcache,
    output logic [2:0]  M_AXI_awprot,
    output logic [1:0]  M_AXI_awlock,
    output logic [3:0]  M_AXI_awqos,
    output logic        M_AXI_awvalid,
    input  logic        M_AXI_awready,
    output logic [31:0] M_AXI_wdata,
    output logic [3:0]  M_AXI_wstrb,
    output logic [5:0]  M_AXI_wid,
    output logic        M_AXI_wlast,
    output logic        M_AXI_wvalid,
    input  logic        M_AXI_wready,
    input  logic [5:0]  M_AXI_bid,
    input  logic [1:0]  M_AXI_bresp,
    input  logic        M_AXI_bvalid,
    output logic        M_AXI_bready,
    output logic [2:0]  dbg_state
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Handshakes: a beat transfers on the rising edge where valid && ready; valid never drops before that.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_FILL = 3'd1,
        ST_ADDR = 3'd2,
        ST_DATA = 3'd3,
        ST_RESP = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    state_t           state;
    logic [31:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             fifo_full;
    logic             push;
    logic             pop;
    logic             flush;
    logic [31:0]      addr_q;
    logic [23:0]      remaining;
    logic             stop_req;
    logic [3:0]       beat;
    logic             unused_ok;
`ifdef HP0_WR_RING_EN
    logic [31:0]      base_q;
    logic [23:0]      words_q;
`endif

    assign unused_ok = ^{M_AXI_bid, cfg_base[5:0], cfg_words[3:0]};

    assign M_AXI_awlen   = 4'(BURST_LEN - 1);
    assign M_AXI_awid    = AXI_ID;
    assign M_AXI_awsize  = 3'b010;
    assign M_AXI_awburst = 2'b01;
    assign M_AXI_awcache = 4'b0011;
    assign M_AXI_awprot  = 3'b000;
    assign M_AXI_awlock  = 2'b00;
    assign M_AXI_awqos   = 4'h0;
    assign M_AXI_wstrb   = 4'hF;
    assign M_AXI_wid     = AXI_ID;
    assign M_AXI_awaddr  = addr_q;
    assign M_AXI_wdata   = mem[rd_ptr];
    assign sts_addr      = addr_q;
    assign dbg_state     = state;

    assign fifo_full = (count == CNT_W'(FIFO_DEPTH));
    assign s_ready   = sts_busy && !fifo_full;
    assign push      = s_valid && s_ready;
    assign pop       = M_AXI_wvalid && M_AXI_wready;
    assign flush     = (state == ST_IDLE) && cfg_start;

    always_ff @(posedge SYS_CLK) begin
        if (push) mem[wr_ptr] <= s_data;
    end

    always_ff @(posedge SYS_CLK) begin
        if (SYS_RST || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge SYS_CLK) begin
        if (SYS_RST) begin
            state         <= ST_IDLE;
            M_AXI_awvalid <= 1'b0;
            M_AXI_wvalid  <= 1'b0;
            M_AXI_wlast   <= 1'b0;
            M_AXI_bready  <= 1'b0;
            sts_busy      <= 1'b0;
            sts_done      <= 1'b0;
            sts_err       <= 1'b0;
            addr_q        <= '0;
            remaining     <= '0;
            stop_req      <= 1'b0;
            beat          <= '0;
`ifdef HP0_WR_RING_EN
            base_q        <= '0;
            words_q       <= '0;
`endif
        end else begin
            sts_done <= 1'b0;
            if (sts_busy && cfg_stop) stop_req <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (cfg_start) begin
                        addr_q    <= {cfg_base[31:6], 6'b0};
                        remaining <= {cfg_words[23:4], 4'b0};
`ifdef HP0_WR_RING_EN
                        base_q    <= {cfg_base[31:6], 6'b0};
                        words_q   <= {cfg_words[23:4], 4'b0};
`endif
                        sts_err   <= 1'b0;
                        stop_req  <= 1'b0;
                        sts_busy  <= 1'b1;
                        state     <= (cfg_words[23:4] == '0) ? ST_DONE : ST_FILL;
                    end
                end
                // A stop only ever takes effect here, between bursts.
                ST_FILL: begin
                    if (stop_req || cfg_stop) begin
                        state <= ST_DONE;
                    end else if (count >= CNT_W'(BURST_LEN)) begin
                        M_AXI_awvalid <= 1'b1;
                        state         <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (M_AXI_awready) begin
                        M_AXI_awvalid <= 1'b0;
                        M_AXI_wvalid  <= 1'b1;
                        M_AXI_wlast   <= 1'b0;
                        beat          <= '0;
                        state         <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (M_AXI_wready) begin
                        beat        <= beat + 1'b1;
                        M_AXI_wlast <= (beat == 4'(BURST_LEN - 2));
                        if (M_AXI_wlast) begin
                            M_AXI_wvalid <= 1'b0;
                            M_AXI_wlast  <= 1'b0;
                            M_AXI_bready <= 1'b1;
                            state        <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    if (M_AXI_bvalid) begin
                        M_AXI_bready <= 1'b0;
                        if (M_AXI_bresp != 2'b00) sts_err <= 1'b1;
                        addr_q    <= addr_q + 32'(BURST_LEN * 4);
                        remaining <= remaining - 24'(BURST_LEN);
                        if (remaining == 24'(BURST_LEN)) begin
`ifdef HP0_WR_RING_EN
                            addr_q    <= base_q;
                            remaining <= words_q;
                            state     <= ST_FILL;
`else
                            state     <= ST_DONE;
`endif
                        end else begin
                            state <= ST_FILL;
                        end
                    end
                end
                ST_DONE: begin
                    sts_done <= 1'b1;
                    sts_busy <= 1'b0;
                    stop_req <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hp0_stream_wr_master.sv
// Directed bench for hp0_stream_wr_master: AXI slave model, stream source and scoreboard run per cycle from tick().
module tb_hp0_stream_wr_master;
    logic        SYS_CLK;
    logic        SYS_RST;
    logic [31:0] cfg_base;
    logic [23:0] cfg_words;
    logic        cfg_start;
    logic        cfg_stop;
    logic        sts_busy;
    logic        sts_done;
    logic        sts_err;
    logic [31:0] sts_addr;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [5:0]  awid;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic [1:0]  awlock;
    logic [3:0]  awqos;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [5:0]  wid;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [5:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [2:0]  dbg_state;

    logic [31:0] exp_q[$];
    logic [31:0] exp_addr_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          stream_left = 0;
    logic [31:0] stream_val = '0;
    bit          stall = 0;
    int          aw_wait = 0;
    int          w_wait = 0;
    int          b_pending = 0;
    int          b_cnt = 0;
    int          aw_cnt = 0;
    int          w_total = 0;
    int          beat_cnt = 0;
    int          done_cnt = 0;
    int          err_burst = -1;
    bit          exp_err = 0;
    bit          prev_aw_stall = 0;
    bit          prev_w_stall = 0;
    logic [31:0] prev_awaddr = '0;
    logic [31:0] prev_wdata = '0;
    logic        prev_wlast = 1'b0;

    hp0_stream_wr_master dut (
        .SYS_CLK(SYS_CLK), .SYS_RST(SYS_RST),
        .cfg_base(cfg_base), .cfg_words(cfg_words), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
        .sts_busy(sts_busy), .sts_done(sts_done), .sts_err(sts_err), .sts_addr(sts_addr),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .M_AXI_awaddr(awaddr), .M_AXI_awlen(awlen), .M_AXI_awid(awid), .M_AXI_awsize(awsize),
        .M_AXI_awburst(awburst), .M_AXI_awcache(awcache), .M_AXI_awprot(awprot),
        .M_AXI_awlock(awlock), .M_AXI_awqos(awqos), .M_AXI_awvalid(awvalid), .M_AXI_awready(awready),
        .M_AXI_wdata(wdata), .M_AXI_wstrb(wstrb), .M_AXI_wid(wid), .M_AXI_wlast(wlast),
        .M_AXI_wvalid(wvalid), .M_AXI_wready(wready),
        .M_AXI_bid(bid), .M_AXI_bresp(bresp), .M_AXI_bvalid(bvalid), .M_AXI_bready(bready),
        .dbg_state(dbg_state)
    );

    initial begin
        SYS_CLK = 1'b0;
        forever #5 SYS_CLK = ~SYS_CLK;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Per-cycle scoreboard: every handshake seen here happens on the next rising edge.
    task automatic monitor();
        if (prev_aw_stall) begin
            check("aw_hold_valid", 64'(awvalid), 64'(1'b1));
            check("aw_hold_addr", 64'(awaddr), 64'(prev_awaddr));
        end
        prev_aw_stall = awvalid && !awready;
        prev_awaddr   = awaddr;
        if (awvalid && awready) begin
            aw_cnt++;
            check("aw_expected", 64'(exp_addr_q.size() != 0), 64'(1'b1));
            if (exp_addr_q.size() != 0) check("awaddr", 64'(awaddr), 64'(exp_addr_q.pop_front()));
            if (stall) aw_wait = $urandom_range(0, 5);
        end
        if (prev_w_stall) begin
            check("w_hold_valid", 64'(wvalid), 64'(1'b1));
            check("w_hold_data", 64'(wdata), 64'(prev_wdata));
            check("w_hold_last", 64'(wlast), 64'(prev_wlast));
        end
        prev_w_stall = wvalid && !wready;
        prev_wdata   = wdata;
        prev_wlast   = wlast;
        if (wvalid && wready) begin
            check("w_expected", 64'(exp_q.size() != 0), 64'(1'b1));
            if (exp_q.size() != 0) check("wdata", 64'(wdata), 64'(exp_q.pop_front()));
            check("wlast", 64'(wlast), 64'(beat_cnt == 15));
            w_total++;
            if (beat_cnt == 15) begin
                beat_cnt = 0;
                b_pending++;
            end else begin
                beat_cnt++;
            end
            if (stall) w_wait = $urandom_range(0, 5);
        end
        if (bvalid && bready) begin
            check("err_before_resp", 64'(sts_err), 64'(exp_err));
            if (bresp != 2'b00) exp_err = 1'b1;
            b_pending--;
            b_cnt++;
        end
        if (sts_done) done_cnt++;
        if (s_valid && s_ready) begin
            exp_q.push_back(s_data);
            stream_val++;
            stream_left--;
        end
    endtask

    task automatic tick();
        @(negedge SYS_CLK);
        cfg_start = 1'b0;
        cfg_stop  = 1'b0;
        if (aw_wait > 0) begin awready = 1'b0; aw_wait--; end else awready = 1'b1;
        if (w_wait > 0) begin wready = 1'b0; w_wait--; end else wready = 1'b1;
        bvalid  = (b_pending > 0);
        bresp   = (b_cnt == err_burst) ? 2'b10 : 2'b00;
        s_valid = (stream_left > 0);
        s_data  = stream_val;
        #1;
        if (!SYS_RST) monitor();
    endtask

    task automatic new_test();
        exp_q.delete();
        exp_addr_q.delete();
        stream_left = 0;
        aw_cnt = 0; b_cnt = 0; w_total = 0; beat_cnt = 0; done_cnt = 0; b_pending = 0;
        exp_err = 1'b0; err_burst = -1; prev_aw_stall = 0; prev_w_stall = 0;
        aw_wait = 0; w_wait = 0;
    endtask

    task automatic start_xfer(input logic [31:0] base, input logic [23:0] words);
        cfg_base  = base;
        cfg_words = words;
        cfg_start = 1'b1;
        tick();
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            tick();
            n++;
        end
        check("done_seen", 64'(done_cnt != 0), 64'(1'b1));
        repeat (3) tick();
        check("done_once", 64'(done_cnt), 64'(1));
        check("busy_after_done", 64'(sts_busy), 64'(1'b0));
    endtask

    task automatic finish_xfer(input int n_bursts, input int budget);
`ifdef HP0_WR_RING_EN
        begin
            int n;
            n = 0;
            while (b_cnt < n_bursts && n < budget) begin
                tick();
                n++;
            end
            check("ring_bursts", 64'(b_cnt), 64'(n_bursts));
            cfg_stop = 1'b1;
        end
`endif
        wait_done(budget);
    endtask

    task automatic wait_state(input logic [2:0] st, input int budget);
        int n;
        n = 0;
        while (dbg_state != st && n < budget) begin
            tick();
            n++;
        end
        check("reach_state", 64'(dbg_state), 64'(st));
    endtask

    initial begin
        SYS_RST = 1'b1; cfg_base = '0; cfg_words = '0; cfg_start = 1'b0; cfg_stop = 1'b0;
        s_data = '0; s_valid = 1'b0; awready = 1'b0; wready = 1'b0;
        bid = 6'd0; bresp = 2'b00; bvalid = 1'b0;
        repeat (3) tick();
        check("rst_awvalid", 64'(awvalid), 64'(1'b0));
        check("rst_wvalid", 64'(wvalid), 64'(1'b0));
        check("rst_wlast", 64'(wlast), 64'(1'b0));
        check("rst_bready", 64'(bready), 64'(1'b0));
        check("rst_s_ready", 64'(s_ready), 64'(1'b0));
        check("rst_busy", 64'(sts_busy), 64'(1'b0));
        check("rst_done", 64'(sts_done), 64'(1'b0));
        check("rst_err", 64'(sts_err), 64'(1'b0));
        check("rst_addr", 64'(sts_addr), 64'(0));
        check("rst_state", 64'(dbg_state), 64'(3'd0));
        SYS_RST = 1'b0;
        tick();
        check("awlen", 64'(awlen), 64'(4'hF));
        check("aw_attr", 64'({awid, awsize, awburst, awcache, awprot, awlock, awqos}),
              64'({6'd0, 3'b010, 2'b01, 4'b0011, 3'b000, 2'b00, 4'h0}));
        check("w_attr", 64'({wid, wstrb}), 64'({6'd0, 4'hF}));

        // T1: two bursts, no back-pressure
        new_test();
        exp_addr_q.push_back(32'h1000_0000);
        exp_addr_q.push_back(32'h1000_0040);
        start_xfer(32'h1000_0000, 24'd32);
        check("t1_busy", 64'(sts_busy), 64'(1'b1));
        check("t1_sts_addr", 64'(sts_addr), 64'(32'h1000_0000));
        stream_val = 32'hA000_0000;
        stream_left = 32;
        finish_xfer(2, 500);
        check("t1_aw_cnt", 64'(aw_cnt), 64'(2));
        check("t1_beats", 64'(w_total), 64'(32));
        check("t1_left", 64'(exp_q.size()), 64'(0));
        check("t1_err", 64'(sts_err), 64'(1'b0));

        // T2: random AW/W stalls, unaligned base and length get masked
        new_test();
        stall = 1;
        aw_wait = $urandom_range(0, 5);
        w_wait = $urandom_range(0, 5);
        for (int i = 0; i < 4; i++) exp_addr_q.push_back(32'h2000_0FC0 + 32'(i * 64));
        start_xfer(32'h2000_0FFF, 24'h45);
        check("t2_sts_addr", 64'(sts_addr), 64'(32'h2000_0FC0));
        stream_val = 32'hB000_0000;
        stream_left = 64;
        finish_xfer(4, 3000);
        check("t2_aw_cnt", 64'(aw_cnt), 64'(4));
        check("t2_beats", 64'(w_total), 64'(64));
        check("t2_left", 64'(exp_q.size()), 64'(0));
        stall = 0;

        // T3: stream stops at 20 words, machine parks in FILL until stopped
        new_test();
        exp_addr_q.push_back(32'h3000_0000);
        start_xfer(32'h3000_0000, 24'd32);
        stream_val = 32'hC000_0000;
        stream_left = 20;
        repeat (120) tick();
        check("t3_aw_cnt", 64'(aw_cnt), 64'(1));
        check("t3_state", 64'(dbg_state), 64'(3'd1));
        check("t3_s_ready", 64'(s_ready), 64'(1'b1));
        check("t3_busy", 64'(sts_busy), 64'(1'b1));
        check("t3_no_done", 64'(done_cnt), 64'(0));
        check("t3_fifo_words", 64'(exp_q.size()), 64'(4));
        check("t3_sts_addr", 64'(sts_addr), 64'(32'h3000_0040));
        cfg_stop = 1'b1;
        wait_done(50);
        check("t3_aw_final", 64'(aw_cnt), 64'(1));

        // T4: SLVERR on the first of two bursts
        new_test();
        err_burst = 0;
        exp_addr_q.push_back(32'h4000_0000);
        exp_addr_q.push_back(32'h4000_0040);
        start_xfer(32'h4000_0000, 24'd32);
        stream_val = 32'hD000_0000;
        stream_left = 32;
        finish_xfer(2, 500);
        check("t4_aw_cnt", 64'(aw_cnt), 64'(2));
        check("t4_err", 64'(sts_err), 64'(1'b1));

        // T5: stop during the first burst's data phase
        new_test();
        exp_addr_q.push_back(32'h5000_0000);
        start_xfer(32'h5000_0000, 24'd64);
        check("t5_err_cleared", 64'(sts_err), 64'(1'b0));
        stream_val = 32'hE000_0000;
        stream_left = 64;
        wait_state(3'd3, 200);
        cfg_stop = 1'b1;
        wait_done(300);
        check("t5_aw_cnt", 64'(aw_cnt), 64'(1));
        check("t5_beats", 64'(w_total), 64'(16));
        check("t5_b_cnt", 64'(b_cnt), 64'(1));

        // T6: empty region completes without touching AW
        new_test();
        start_xfer(32'h7000_0000, 24'h00000F);
        check("t6_done_early", 64'(sts_done), 64'(1'b0));
        tick();
        check("t6_done", 64'(sts_done), 64'(1'b1));
        check("t6_busy", 64'(sts_busy), 64'(1'b0));
        tick();
        check("t6_done_clear", 64'(sts_done), 64'(1'b0));
        check("t6_aw_cnt", 64'(aw_cnt), 64'(0));

`ifdef HP0_WR_RING_EN
        // Ring capture over a one-burst region wraps back to base
        new_test();
        for (int i = 0; i < 3; i++) exp_addr_q.push_back(32'h6000_0000);
        start_xfer(32'h6000_0000, 24'd16);
        stream_val = 32'hF000_0000;
        stream_left = 48;
        finish_xfer(3, 800);
        check("ring_aw_cnt", 64'(aw_cnt), 64'(3));
`endif

        // Reset in the middle of a burst drops every valid at once
        new_test();
        exp_addr_q.push_back(32'h8000_0000);
        start_xfer(32'h8000_0000, 24'd32);
        stream_val = 32'h1234_0000;
        stream_left = 32;
        wait_state(3'd3, 200);
        SYS_RST = 1'b1;
        tick();
        check("mid_rst_wvalid", 64'(wvalid), 64'(1'b0));
        check("mid_rst_awvalid", 64'(awvalid), 64'(1'b0));
        check("mid_rst_busy", 64'(sts_busy), 64'(1'b0));
        check("mid_rst_s_ready", 64'(s_ready), 64'(1'b0));
        check("mid_rst_state", 64'(dbg_state), 64'(3'd0));
        SYS_RST = 1'b0;
        new_test();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
